// File: rtl/modulate_tx_pkg.sv
// Shared definitions for the modulate_tx transmit modulator.
//   mode_e      : modulation mode encodings
//   PIPE_LAT    : clock edges from accumulator sample to wave_out
//   HALF_PI_Q30 : pi/2 in Q30, seed for the sine table builder
package modulate_tx_pkg;

  typedef enum logic [1:0] {
    MODE_CARRIER = 2'b00,
    MODE_AM      = 2'b01,
    MODE_FM      = 2'b10,
    MODE_PM      = 2'b11
  } mode_e;

  localparam int     PIPE_LAT    = 5;
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

endpackage

// File: rtl/modulate_sin_lut.sv
// Quarter-wave sine ROM with quadrant fold and sign restore.
//   clk_in  : clock
//   RST     : synchronous active-high reset, clears both register stages
//   i_phase : top LUT_ADDR+2 phase bits, upper two are the quadrant
//   o_sin   : signed sine sample, two cycles after i_phase
module modulate_sin_lut
  import modulate_tx_pkg::*;
#(
  parameter int LUT_ADDR     = 10,
  parameter int OUTPUT_WIDTH = 8
) (
  input  logic                           clk_in,
  input  logic                           RST,
  input  logic [LUT_ADDR+1:0]            i_phase,
  output logic signed [OUTPUT_WIDTH-1:0] o_sin
);

  localparam int DEPTH = 2 ** LUT_ADDR;
  localparam logic signed [OUTPUT_WIDTH-1:0] AMP = OUTPUT_WIDTH'((1 << (OUTPUT_WIDTH - 1)) - 1);

  // Elaboration-time table entry: round(AMP * sin(pi/2 * k / DEPTH)),
  // evaluated with a Q30 Taylor series so no real arithmetic reaches synthesis.
  function automatic logic signed [OUTPUT_WIDTH-1:0] sin_entry(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (HALF_PI_Q30 * longint'(k)) >>> LUT_ADDR;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 10; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return OUTPUT_WIDTH'((sum * longint'(AMP) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic signed [OUTPUT_WIDTH-1:0] w_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = sin_entry(g);
  end

  logic [LUT_ADDR-1:0]            w_addr;
  logic [LUT_ADDR-1:0]            r_addr_p2;
  logic                           r_full_p2;
  logic                           r_neg_p2;
  logic signed [OUTPUT_WIDTH-1:0] w_mag;
  logic signed [OUTPUT_WIDTH-1:0] r_sin_p3;

  assign w_addr = i_phase[LUT_ADDR-1:0];
  assign w_mag  = r_full_p2 ? AMP : w_rom[r_addr_p2];
  assign o_sin  = r_sin_p3;

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_addr_p2 <= '0;
      r_full_p2 <= 1'b0;
      r_neg_p2  <= 1'b0;
      r_sin_p3  <= '0;
    end else begin
      // S2: fold odd quadrants; mirrored address DEPTH sits one past the table
      r_addr_p2 <= i_phase[LUT_ADDR] ? -w_addr : w_addr;
      r_full_p2 <= i_phase[LUT_ADDR] && (w_addr == '0);
      r_neg_p2  <= i_phase[LUT_ADDR+1];
      // S3: table read and sign restore
      r_sin_p3  <= r_neg_p2 ? -w_mag : w_mag;
    end
  end

endmodule

// File: rtl/modulate_tx.sv
// AM/FM/PM carrier modulator feeding a DAC at clk_in rate.
//   clk_in     : sole clock
//   RST        : synchronous active-high reset
//   Fre_word   : unsigned carrier phase increment per cycle
//   mode       : 00 carrier, 01 AM, 10 FM, 11 PM
//   Kf         : unsigned FM deviation gain
//   msg_in     : signed message sample, captured when msg_valid is high
//   msg_valid  : message capture strobe
//   wave_out   : signed modulated carrier
//   wave_valid : high once the pipeline carries post-reset samples
module modulate_tx
  import modulate_tx_pkg::*;
#(
  parameter int PHASE_WIDTH  = 32,
  parameter int INPUT_WIDTH  = 12,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LUT_ADDR     = 10,
  parameter int FM_SHIFT     = 14
) (
  input  logic                           clk_in,
  input  logic                           RST,
  input  logic [PHASE_WIDTH-1:0]         Fre_word,
  input  logic [1:0]                     mode,
  input  logic [15:0]                    Kf,
  input  logic signed [INPUT_WIDTH-1:0]  msg_in,
  input  logic                           msg_valid,
  output logic signed [OUTPUT_WIDTH-1:0] wave_out,
  output logic                           wave_valid
);

  localparam int TOP_W = LUT_ADDR + 2;

  // (sin * env) >>> (INPUT_WIDTH-1), floor; result always fits OUTPUT_WIDTH
  function automatic logic signed [OUTPUT_WIDTH-1:0] am_scale(
    input logic signed [OUTPUT_WIDTH-1:0] s,
    input logic [INPUT_WIDTH-2:0]         env
  );
    logic signed [OUTPUT_WIDTH+INPUT_WIDTH-1:0] prod;
    prod = (OUTPUT_WIDTH + INPUT_WIDTH)'(s) * $signed((OUTPUT_WIDTH + INPUT_WIDTH)'(env));
    return OUTPUT_WIDTH'(prod >>> (INPUT_WIDTH - 1));
  endfunction

  logic signed [INPUT_WIDTH-1:0]  r_msg;
  mode_e                          r_mode;
  logic [15:0]                    r_kf;
  logic [PHASE_WIDTH-1:0]         r_acc;

  logic [PHASE_WIDTH-1:0]         r_acc_p0;
  mode_e                          r_mode_p0;
  logic signed [INPUT_WIDTH-1:0]  r_msg_p0;

  logic [TOP_W-1:0]               r_ph_p1;
  logic                           r_am_p1, r_am_p2, r_am_p3;
  logic [INPUT_WIDTH-2:0]         r_env_p1, r_env_p2, r_env_p3;

  logic signed [OUTPUT_WIDTH-1:0] r_wave_p4;
  logic [PIPE_LAT-1:0]            r_vld_p;

  logic signed [PHASE_WIDTH-1:0]  w_msg_ext;
  logic signed [PHASE_WIDTH-1:0]  w_kf_ext;
  logic signed [PHASE_WIDTH-1:0]  w_fm_prod;
  logic [PHASE_WIDTH-1:0]         w_foff;
  logic [PHASE_WIDTH-1:0]         w_pm;
  logic [PHASE_WIDTH-1:0]         w_ph;
  logic signed [OUTPUT_WIDTH-1:0] w_sin;

  assign w_msg_ext = {{(PHASE_WIDTH-INPUT_WIDTH){r_msg[INPUT_WIDTH-1]}}, r_msg};
  assign w_kf_ext  = $signed({{(PHASE_WIDTH-16){1'b0}}, r_kf});
  assign w_fm_prod = w_msg_ext * w_kf_ext;
  assign w_foff    = (r_mode == MODE_FM) ? PHASE_WIDTH'(w_fm_prod <<< FM_SHIFT) : '0;
  assign w_pm      = (r_mode_p0 == MODE_PM) ? {r_msg_p0, {(PHASE_WIDTH-INPUT_WIDTH){1'b0}}} : '0;
  assign w_ph      = r_acc_p0 + w_pm;

  modulate_sin_lut #(
    .LUT_ADDR     (LUT_ADDR),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_lut (
    .clk_in  (clk_in),
    .RST     (RST),
    .i_phase (r_ph_p1),
    .o_sin   (w_sin)
  );

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_msg     <= '0;
      r_mode    <= MODE_CARRIER;
      r_kf      <= '0;
      r_acc     <= '0;
      r_acc_p0  <= '0;
      r_mode_p0 <= MODE_CARRIER;
      r_msg_p0  <= '0;
      r_ph_p1   <= '0;
      r_am_p1   <= 1'b0;
      r_am_p2   <= 1'b0;
      r_am_p3   <= 1'b0;
      r_env_p1  <= '0;
      r_env_p2  <= '0;
      r_env_p3  <= '0;
      r_wave_p4 <= '0;
      r_vld_p   <= '0;
    end else begin
      if (msg_valid) r_msg <= msg_in;
      r_mode <= mode_e'(mode);
      r_kf   <= Kf;
      // S0: snapshot this sample's phase and controls, advance the accumulator
      r_acc     <= r_acc + Fre_word + w_foff;
      r_acc_p0  <= r_acc;
      r_mode_p0 <= r_mode;
      r_msg_p0  <= r_msg;
      // S1: PM offset; envelope is msg>>>1 in offset binary (flip sign bit)
      r_ph_p1   <= TOP_W'(w_ph >> (PHASE_WIDTH - TOP_W));
      r_am_p1   <= (r_mode_p0 == MODE_AM);
      r_env_p1  <= {~r_msg_p0[INPUT_WIDTH-1], r_msg_p0[INPUT_WIDTH-2:1]};
      // S2/S3: controls ride alongside the sine lookup
      r_am_p2   <= r_am_p1;
      r_env_p2  <= r_env_p1;
      r_am_p3   <= r_am_p2;
      r_env_p3  <= r_env_p2;
      // S4: envelope and output
      r_wave_p4 <= r_am_p3 ? am_scale(w_sin, r_env_p3) : w_sin;
      r_vld_p   <= {r_vld_p[PIPE_LAT-2:0], 1'b1};
    end
  end

  assign wave_out   = r_wave_p4;
  assign wave_valid = r_vld_p[PIPE_LAT-1];

endmodule

// File: tb/tb_modulate_tx.sv
module tb_modulate_tx;

  logic               clk_in = 1'b0;
  logic               RST;
  logic [31:0]        Fre_word;
  logic [1:0]         mode;
  logic [15:0]        Kf;
  logic signed [11:0] msg_in;
  logic               msg_valid;
  logic signed [7:0]  wave_out;
  logic               wave_valid;

  always #5 clk_in = ~clk_in;

  modulate_tx dut (
    .clk_in     (clk_in),
    .RST        (RST),
    .Fre_word   (Fre_word),
    .mode       (mode),
    .Kf         (Kf),
    .msg_in     (msg_in),
    .msg_valid  (msg_valid),
    .wave_out   (wave_out),
    .wave_valid (wave_valid)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: registered controls, running phase, queue of pending outputs
  logic [31:0] m_acc;
  int          m_mode, m_msg, m_kf, m_k;
  int          m_q[$];
  int          exp_wave, exp_vld;

  function automatic int sine_ref(input int idx);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 4096.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int sample_value(input logic [31:0] acc, input int md, input int msg);
    logic [31:0] ph;
    int          s;
    ph = acc + ((md == 3) ? 32'(msg * 1048576) : 32'd0);
    s  = sine_ref(int'(ph >> 20));
    if (md == 1) return (s * (1024 + (msg >>> 1))) >>> 11;
    return s;
  endfunction

  task automatic model_edge();
    logic [31:0] foff;
    if (RST) begin
      m_acc = 0; m_mode = 0; m_msg = 0; m_kf = 0; m_k = 0;
      m_q.delete();
      exp_wave = 0; exp_vld = 0;
    end else begin
      m_q.push_back(sample_value(m_acc, m_mode, m_msg));
      foff  = (m_mode == 2) ? 32'(longint'(m_msg) * longint'(m_kf) * 64'sd16384) : 32'd0;
      m_acc = m_acc + Fre_word + foff;
      m_mode = int'(mode);
      m_kf   = int'(Kf);
      if (msg_valid) m_msg = int'(msg_in);
      m_k++;
      if (m_k >= 5) begin
        exp_wave = m_q.pop_front();
        exp_vld  = 1;
      end else begin
        exp_wave = 0;
        exp_vld  = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    chk({tag, "_vld"}, int'(wave_valid), exp_vld);
    chk({tag, "_wave"}, int'(wave_out), exp_wave);
  endtask

  task automatic run(input string tag, input int md, input logic [31:0] fw,
                     input int kf, input int msg, input int n);
    mode      = 2'(md);
    Fre_word  = fw;
    Kf        = 16'(kf);
    msg_in    = 12'(msg);
    msg_valid = 1'b1;
    tick(tag);
    msg_valid = 1'b0;
    repeat (n - 1) tick(tag);
  endtask

  initial begin
    RST = 1'b1; Fre_word = '0; mode = '0; Kf = '0; msg_in = '0; msg_valid = 1'b0;
    m_acc = 0; m_mode = 0; m_msg = 0; m_kf = 0; m_k = 0; exp_wave = 0; exp_vld = 0;

    repeat (3) tick("reset");
    RST = 1'b0;

    run("carrier", 0, 32'h4000_0000, 0, 0, 16);
    run("pm_pos",  3, 32'h0, 0, 1024, 12);
    run("pm_neg",  3, 32'h0, 0, -1024, 12);
    run("pm_pi",   3, 32'h0, 0, -2048, 12);
    run("fm_pos",  2, 32'h0, 256, 256, 12);
    run("fm_neg",  2, 32'h0, 256, -256, 12);
    repeat (8) tick("fm_hold");
    run("am_zero", 1, 32'h4000_0000, 0, 0, 12);
    run("am_max",  1, 32'h4000_0000, 0, 2047, 12);
    run("am_min",  1, 32'h4000_0000, 0, -2048, 12);
    run("wrap",    0, 32'hC000_0000, 0, 0, 12);

    RST = 1'b1;
    tick("midrst");
    RST = 1'b0;
    run("restart", 0, 32'h4000_0000, 0, 0, 12);

    // capture strobe coincident with reset must be discarded
    RST = 1'b1; msg_valid = 1'b1; msg_in = 12'sd500;
    tick("rst_msg");
    RST = 1'b0; msg_valid = 1'b0; mode = 2'b11; Fre_word = '0;
    repeat (10) tick("rst_msg_pm");

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mode     = 2'($urandom);
        Fre_word = $urandom >> $urandom_range(0, 12);
        Kf       = 16'($urandom);
      end
      msg_in    = 12'($urandom);
      msg_valid = ($urandom_range(0, 3) == 0);
      RST       = ($urandom_range(0, 199) == 0);
      tick("rand");
    end
    RST = 1'b0;
    repeat (6) tick("tail");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
